// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
//   - FSM state encoding (2-bit)
//   - RV32M funct3 op codes (3-bit)
//   - iteration count
//   - operand-signedness decode helpers
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'd0,
    MD_ST_CALC = 2'd1,
    MD_ST_FIX  = 2'd2,
    MD_ST_DONE = 2'd3
  } md_state_e;

  localparam logic [2:0] MD_OP_MUL    = 3'b000;
  localparam logic [2:0] MD_OP_MULH   = 3'b001;
  localparam logic [2:0] MD_OP_MULHSU = 3'b010;
  localparam logic [2:0] MD_OP_MULHU  = 3'b011;
  localparam logic [2:0] MD_OP_DIV    = 3'b100;
  localparam logic [2:0] MD_OP_DIVU   = 3'b101;
  localparam logic [2:0] MD_OP_REM    = 3'b110;
  localparam logic [2:0] MD_OP_REMU   = 3'b111;

  localparam int MD_ITER = 32;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic src1_is_signed(input logic [2:0] op);
    return (op == MD_OP_MULH) || (op == MD_OP_MULHSU) ||
           (op == MD_OP_DIV)  || (op == MD_OP_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic src2_is_signed(input logic [2:0] op);
    return (op == MD_OP_MULH) || (op == MD_OP_DIV) || (op == MD_OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes,
// with sign correction applied in a single FIX cycle.
// Fixed latency: Start accepted at edge N, Done high in the cycle after
// edge N+33.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   Start      operation request, sampled only while idle
//   Flush      synchronous abort, returns the unit to idle
//   MD_op      RV32M funct3 (MUL..REMU)
//   Src1       rs1 (multiplicand / dividend)
//   Src2       rs2 (multiplier / divisor)
//   Busy       unit occupied, pipeline must stall
//   Done       one-cycle pulse, MD_Result valid
//   MD_Result  registered result, held until the next FIX cycle
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Start,
  input  logic            Flush,
  input  logic [2:0]      MD_op,
  input  logic [XLEN-1:0] Src1,
  input  logic [XLEN-1:0] Src2,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] MD_Result
);

  md_state_e         state, state_nxt;
  logic [2:0]        op;
  logic [CNT_W-1:0]  cnt;
  logic              sign_diff;   // s1 ^ s2: product and quotient sign
  logic              rem_neg;     // s1: remainder sign
  logic              div_zero;
  logic [XLEN-1:0]   mcand;
  logic [2*XLEN-1:0] prod;        // low half starts as the multiplier
  logic [XLEN-1:0]   divisor;
  logic [XLEN-1:0]   rem;
  logic [XLEN-1:0]   quo;         // starts as the dividend, shifts out MSB first

  logic              accept;
  logic              last_iter;
  logic              s1_neg, s2_neg;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   result;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic neg);
    // 0x80000000 stays 0x80000000 and is read as unsigned from here on
    return neg ? (~v + 1'b1) : v;
  endfunction

  assign accept    = (state == MD_ST_IDLE) && Start && !Flush;
  assign last_iter = (cnt == CNT_W'(XLEN - 1));
  assign s1_neg    = src1_is_signed(MD_op) && Src1[XLEN-1];
  assign s2_neg    = src2_is_signed(MD_op) && Src2[XLEN-1];

  assign Busy = (state != MD_ST_IDLE);
  assign Done = (state == MD_ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = MD_ST_IDLE;
    end else begin
      unique case (state)
        MD_ST_IDLE: if (Start)     state_nxt = MD_ST_CALC;
        MD_ST_CALC: if (last_iter) state_nxt = MD_ST_FIX;
        MD_ST_FIX:                 state_nxt = MD_ST_DONE;
        MD_ST_DONE:                state_nxt = MD_ST_IDLE;
        default:                   state_nxt = MD_ST_IDLE;
      endcase
    end
  end

  // Iteration datapath
  assign mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? mcand : '0)};
  assign div_shift = {rem, quo[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, divisor};

  // Sign correction and result select. A zero divisor leaves rem equal to
  // |Src1|, so the remainder sign fix alone restores the latched Src1; only
  // the quotient needs forcing. The signed overflow case yields 0x80000000
  // and remainder 0 naturally.
  always_comb begin
    prod_fix = sign_diff ? (~prod + 1'b1) : prod;
    quo_fix  = div_zero ? '1 : (sign_diff ? (~quo + 1'b1) : quo);
    rem_fix  = rem_neg ? (~rem + 1'b1) : rem;
    unique case (op)
      MD_OP_MUL:                           result = prod_fix[XLEN-1:0];
      MD_OP_MULH, MD_OP_MULHSU,
      MD_OP_MULHU:                         result = prod_fix[2*XLEN-1:XLEN];
      MD_OP_DIV, MD_OP_DIVU:               result = quo_fix;
      default:                             result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= '0;
      cnt       <= '0;
      sign_diff <= 1'b0;
      rem_neg   <= 1'b0;
      div_zero  <= 1'b0;
      mcand     <= '0;
      prod      <= '0;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      MD_Result <= '0;
    end else if (accept) begin
      op        <= MD_op;
      cnt       <= '0;
      sign_diff <= s1_neg ^ s2_neg;
      rem_neg   <= s1_neg;
      div_zero  <= (Src2 == '0);
      mcand     <= magnitude(Src1, s1_neg);
      prod      <= {{XLEN{1'b0}}, magnitude(Src2, s2_neg)};
      divisor   <= magnitude(Src2, s2_neg);
      rem       <= '0;
      quo       <= magnitude(Src1, s1_neg);
    end else if (state == MD_ST_CALC && !Flush) begin
      // ---- CALC: one radix-2 step per cycle ----
      cnt <= cnt + CNT_W'(1);
      if (op[2]) begin
        // non-negative trial difference is always below the divisor,
        // so it fits back into XLEN bits
        rem <= div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], ~div_diff[XLEN]};
      end else begin
        prod <= {mul_sum, prod[XLEN-1:1]};
      end
    end else if (state == MD_ST_FIX && !Flush) begin
      // ---- FIX: sign correction and result register ----
      MD_Result <= result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start;
  logic        Flush;
  logic [2:0]  MD_op;
  logic [31:0] Src1;
  logic [31:0] Src2;
  logic        Busy;
  logic        Done;
  logic [31:0] MD_Result;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
    .Flush     (Flush),
    .MD_op     (MD_op),
    .Src1      (Src1),
    .Src2      (Src2),
    .Busy      (Busy),
    .Done      (Done),
    .MD_Result (MD_Result)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_exp;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Independent reference using 64-bit native arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    r = '0;
    case (op)
      3'd0: begin r = ua * ub; return r[31:0];  end
      3'd1: begin r = sa * sb; return r[63:32]; end
      3'd2: begin r = sa * ub; return r[63:32]; end
      3'd3: begin r = ua * ub; return r[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; r = sa / sb; return r[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; r = ua / ub; return r[31:0]; end
      3'd6: begin if (b == 0) return a; r = sa % sb; return r[31:0]; end
      default: begin if (b == 0) return a; r = ua % ub; return r[31:0]; end
    endcase
  endfunction

  // Scoreboard: every Done pops one expected result
  always @(negedge clk) begin
    if (rst_n && Done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result 0x%08h with no request pending", MD_Result);
      end else begin
        check("scoreboard_result", MD_Result, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    MD_op = op; Src1 = a; Src2 = b; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat, busy_cnt;
    bit got;
    exp_q.push_back(exp);
    last_exp = exp;
    issue(op, a, b);
    lat = 0; busy_cnt = 0; got = 0;
    while (lat < 100 && !got) begin
      @(negedge clk);
      lat++;
      if (Done) got = 1;
      else if (Busy) busy_cnt++;
    end
    check({name, "_latency"}, 32'(lat), 32'd34);
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd33);
    @(negedge clk);
    check({name, "_done_pulse"}, {30'd0, Done, Busy}, 32'd0);
  endtask

  initial begin
    int lat, dones;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1]  = '{3'd1, 32'h80000000,  32'h80000000, 32'h40000000};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF};
    vecs[6]  = '{3'd5, 32'd100,       32'd7,        32'd14};
    vecs[7]  = '{3'd7, 32'd100,       32'd7,        32'd2};
    vecs[8]  = '{3'd5, 32'd5,         32'd0,        32'hFFFFFFFF};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,        32'd5};
    vecs[10] = '{3'd4, 32'h80000000,  32'hFFFFFFFF, 32'h80000000};
    vecs[11] = '{3'd6, 32'h80000000,  32'hFFFFFFFF, 32'd0};
    vecs[12] = '{3'd4, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFFF};
    vecs[13] = '{3'd6, 32'hFFFFFFF9,  32'd0,        32'hFFFFFFF9};
    vecs[14] = '{3'd1, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF};

    rst_n = 1'b0; Start = 1'b0; Flush = 1'b0;
    MD_op = '0; Src1 = '0; Src2 = '0;
    last_exp = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {Busy, Done, 30'd0}, 32'd0);
    check("reset_result", MD_Result, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i == 4) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 300)) : $urandom);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, ref_md(rop, ra, rb));
    end

    // Flush at cycle 10 of a multiply: no Done, result untouched
    issue(3'd0, 32'd1234, 32'd5678);
    lat = 0;
    while (lat < 10) begin @(negedge clk); lat++; end
    Flush = 1'b1;
    @(posedge clk);
    #1 Flush = 1'b0;
    @(negedge clk);
    check("flush_busy_drop", {31'd0, Busy}, 32'd0);
    dones = done_cnt;
    repeat (40) @(negedge clk);
    check("flush_no_done", 32'(done_cnt - dones), 32'd0);
    check("flush_result_held", MD_Result, last_exp);

    // Second Start at cycle 5 is ignored: exactly one Done with the first result
    exp_q.push_back(32'd600);
    last_exp = 32'd600;
    dones = done_cnt;
    issue(3'd0, 32'd20, 32'd30);
    lat = 0;
    while (lat < 5) begin @(negedge clk); lat++; end
    MD_op = 3'd5; Src1 = 32'd99; Src2 = 32'd3; Start = 1'b1;
    @(posedge clk);
    #1 Start = 1'b0;
    repeat (60) @(negedge clk);
    check("ignored_start_one_done", 32'(done_cnt - dones), 32'd1);

    // Asynchronous reset in the middle of CALC
    issue(3'd0, 32'd9, 32'd9);
    lat = 0;
    while (lat < 10) begin @(negedge clk); lat++; end
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", {Busy, Done, 30'd0}, 32'd0);
    check("async_reset_result", MD_Result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset_mul", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multi-cycle RV32M multiply/divide unit that sits beside the single-cycle ALU in the EX stage. It accepts the same Src1/Src2 operand pair plus an M-extension op code. It signals Busy so the hazard unit stalls the pipeline, and it returns a registered 32-bit result with a one-cycle Done pulse. It implements radix-2 shift-add multiplication and restoring division, with sign pre/post-correction.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must hold the value XLEN.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
Start  input  1  request; sampled only when Busy=0
Flush  input  1  synchronous abort from the pipeline (branch/exception)
MD_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
Src1  input  32  rs1 (multiplicand/dividend)
Src2  input  32  rs2 (multiplier/divisor)
Busy  output  1  unit occupied; pipeline must stall
Done  output  1  one-cycle pulse; MD_Result valid
MD_Result  output  32  registered result

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, Busy=0, Done=0, MD_Result=0, counter=0, internal accumulators=0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - On Start=1 and Flush=0: latch MD_op.
  - Compute operand signs: signed for MULH/DIV/REM on both operands, signed Src1 only for MULHSU, unsigned otherwise.
  - Load absolute values, clear counter, go to CALC.
- CALC: exactly XLEN (32) iterations, one per cycle.
  - Multiply: 64-bit product register; add multiplicand when multiplier LSB=1, then shift right 1.
  - Divide: 33-bit partial remainder; shift left 1, trial subtract divisor, set quotient bit when the result is non-negative.
  - After the 32nd iteration, go to FIX.
- FIX: one cycle.
  - Apply sign correction: negate product if signs differ; quotient sign = s1 XOR s2; remainder sign = s1.
  - Select the result: MUL = low 32 bits; MULH/MULHSU/MULHU = high 32 bits; DIV/DIVU = quotient; REM/REMU = remainder.
  - Register the result into MD_Result and go to DONE.
- DONE: Done=1 for this cycle only, then go to IDLE.
- Latency: Start sampled at edge N; Done is high during the cycle after edge N+33, fixed at 34 cycles from accept to result regardless of operands.
- Busy=1 in CALC, FIX and DONE. Busy=0 in IDLE, including the Start cycle itself (Busy is registered).
- Start while Busy=1 is ignored, with no queuing. A Start in the DONE cycle is also ignored; the requester reissues it.
- MD_Result holds its value until the next FIX cycle. It is not cleared on Start.
- Division special cases (same 34-cycle latency, forced in FIX):
  - Divisor=0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = Src1 as latched.
  - Overflow, DIV with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, REM = 0.
- Flush=1 in any state: next state IDLE, Busy=0 next cycle, Done not asserted, MD_Result unchanged. Flush has priority over Start in IDLE.
- Reset mid-operation: immediate return to reset values; no Done.
- Width rules:
  - Absolute value of 0x80000000 is held as an unsigned 32-bit 0x80000000, so magnitudes are treated as unsigned throughout.
  - Product is 64 bits; all negation is two's complement at full width.

Decomposition:
- Add to SYSTEM_DEF.vh:
  - `MD_OP_MUL .. `MD_OP_REMU (3-bit funct3 codes).
  - FSM state encodings `MD_ST_IDLE/CALC/FIX/DONE (2-bit).
  - `MD_ITER = 32.
- The decoder uses the same MD_OP codes to drive MD_op and select MD_Result over ALU_Result in the writeback mux.
- No sub-module: the datapath and FSM share counters and registers tightly, so it is a single module.

Test Plan:
- MUL Src1=7, Src2=0xFFFFFFFD (-3) -> MD_Result=0xFFFFFFEB; Done exactly 34 cycles after Start; Busy high 33 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Start MUL, then Flush at cycle 10 -> Busy=0 on next cycle, no Done, MD_Result keeps its prior value. A second Start at cycle 5 of an operation is ignored, with exactly one Done.
- rst_n dropped asynchronously mid-CALC -> Busy/Done/MD_Result = 0 immediately. A new Start after release completes normally with correct value and latency.
